rasterizer: RTL and testbench

Drawing engine upstream of the 214x160x3-bit framebuffer. It accepts drawing commands from the CPU over a valid/ready handshake and emits one framebuffer write per clock into the framebuffer's write port. The VGA output controller reads the same framebuffer independently through the other port.

---
 rtl/vgacpu_pkg.sv | 38 +++
 rtl/rasterizer_if.sv | 24 ++
 rtl/raster_addr_gen.sv | 77 +++++++
 rtl/rasterizer.sv | 135 +++++++++++++
 tb/tb_rasterizer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vgacpu_pkg.sv
// Shared framebuffer geometry, drawing opcodes and payload types for the
// rasterizer, framebuffer and VGA controller.
package vgacpu_pkg;

    localparam int unsigned FB_WIDTH    = 214;
    localparam int unsigned FB_HEIGHT   = 160;
    localparam int unsigned FB_A_WIDTH  = 16;
    localparam int unsigned FB_D_WIDTH  = 3;
    localparam int unsigned COORD_WIDTH = 8;

    typedef enum logic [1:0] {
        NOP       = 2'd0,
        PLOT      = 2'd1,
        FILL_RECT = 2'd2,
        CLEAR     = 2'd3
    } raster_op_e;

    typedef logic [FB_D_WIDTH-1:0]  pixel_t;
    typedef logic [FB_A_WIDTH-1:0]  fb_addr_t;
    typedef logic [COORD_WIDTH-1:0] coord_t;

    typedef struct packed {
        raster_op_e op;
        coord_t     x0;
        coord_t     y0;
        coord_t     x1;
        coord_t     y1;
        pixel_t     colour;
    } raster_cmd_t;

    // y*214 as a constant shift-add (214 = 128+64+16+4+2)
    function automatic fb_addr_t row_base_of(coord_t y);
        fb_addr_t yw;
        yw = FB_A_WIDTH'(y);
        return (yw << 7) + (yw << 6) + (yw << 4) + (yw << 2) + (yw << 1);
    endfunction

endpackage

// File: rtl/rasterizer_if.sv
// Drawing command channel from the CPU: valid/ready handshake plus payload.
interface rasterizer_if;
    import vgacpu_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    raster_op_e cmd_op;
    coord_t     cmd_x0;
    coord_t     cmd_y0;
    coord_t     cmd_x1;
    coord_t     cmd_y1;
    pixel_t     cmd_colour;

    modport master (
        output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour,
        output cmd_ready
    );

endinterface

// File: rtl/raster_addr_gen.sv
// Raster-order walker: x/y counters, row_base accumulator and the write
// address register, which drives the framebuffer address directly.
module raster_addr_gen
    import vgacpu_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     load_i,
    input  logic     step_i,
    input  coord_t   x0_i,
    input  coord_t   y0_i,
    input  coord_t   x1_i,
    input  coord_t   y1_i,
    output fb_addr_t addr_o,
    output logic     done_c
);

    localparam fb_addr_t ROW_STEP = FB_A_WIDTH'(FB_WIDTH);

    coord_t   x_q, x_d, y_q, y_d;
    coord_t   x0_q, x0_d, x1_q, x1_d, y1_q, y1_d;
    fb_addr_t row_base_q, row_base_d, addr_q, addr_d;

    // Row wrap re-derives the address from row_base so no multiply is needed
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        if (load_i) begin
            x_d        = x0_i;
            y_d        = y0_i;
            x0_d       = x0_i;
            x1_d       = x1_i;
            y1_d       = y1_i;
            row_base_d = row_base_of(y0_i);
            addr_d     = row_base_of(y0_i) + FB_A_WIDTH'(x0_i);
        end else if (step_i) begin
            if (x_q == x1_q) begin
                x_d        = x0_q;
                y_d        = y_q + COORD_WIDTH'(1);
                row_base_d = row_base_q + ROW_STEP;
                addr_d     = row_base_q + ROW_STEP + FB_A_WIDTH'(x0_q);
            end else begin
                x_d    = x_q + COORD_WIDTH'(1);
                addr_d = addr_q + FB_A_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            x0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign done_c = (x_q == x1_q) && (y_q == y1_q);

endmodule

// File: rtl/rasterizer.sv
// Drawing engine: accepts PLOT/FILL_RECT/CLEAR commands and streams one
// framebuffer write per clock in raster order.
module rasterizer
    import vgacpu_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst_async,
    rasterizer_if.slave  cmd,
    output logic         busy,
    output logic         fb_write_en,
    output fb_addr_t     fb_write_addr,
    output pixel_t       fb_write_pixel
);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_e;

    localparam coord_t X_LIMIT = COORD_WIDTH'(FB_WIDTH);
    localparam coord_t Y_LIMIT = COORD_WIDTH'(FB_HEIGHT);
    localparam coord_t X_LAST  = COORD_WIDTH'(FB_WIDTH - 1);
    localparam coord_t Y_LAST  = COORD_WIDTH'(FB_HEIGHT - 1);

    state_e      state_q, state_d;
    raster_cmd_t cmd_q, cmd_d;
    logic        wr_en_q, wr_en_d;
    pixel_t      pixel_q, pixel_d;
    logic        busy_q, busy_d;
    coord_t      rx0, ry0, rx1, ry1;
    logic        region_empty_c;
    logic        accept_c;
    logic        ag_load, ag_step, ag_done;

    assign cmd.cmd_ready = (state_q == IDLE);
    assign accept_c      = cmd.cmd_valid && cmd.cmd_ready;

    always_comb begin
        cmd_d = cmd_q;
        if (accept_c) begin
            cmd_d = '{op: cmd.cmd_op, x0: cmd.cmd_x0, y0: cmd.cmd_y0,
                      x1: cmd.cmd_x1, y1: cmd.cmd_y1, colour: cmd.cmd_colour};
        end
    end

    // Region derivation and clipping; no corner swapping is done
    always_comb begin
        rx0 = cmd_q.x0;
        ry0 = cmd_q.y0;
        rx1 = cmd_q.x1;
        ry1 = cmd_q.y1;
        case (cmd_q.op)
            PLOT: begin
                rx1 = cmd_q.x0;
                ry1 = cmd_q.y0;
            end
            CLEAR: begin
                rx0 = '0;
                ry0 = '0;
                rx1 = X_LAST;
                ry1 = Y_LAST;
            end
            default: ;
        endcase
        if (rx1 > X_LAST) rx1 = X_LAST;
        if (ry1 > Y_LAST) ry1 = Y_LAST;
        region_empty_c = (rx0 >= X_LIMIT) || (ry0 >= Y_LIMIT) ||
                         (rx0 > rx1) || (ry0 > ry1);
    end

    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c && (cmd.cmd_op != NOP)) state_d = SETUP;
            SETUP:   state_d = region_empty_c ? IDLE : DRAW;
            DRAW:    if (ag_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The first write is registered out of SETUP so DRAW cycles carry strobes
    always_comb begin
        ag_load = 1'b0;
        ag_step = 1'b0;
        wr_en_d = 1'b0;
        pixel_d = pixel_q;
        busy_d  = (state_d != IDLE);
        case (state_q)
            SETUP: if (!region_empty_c) begin
                ag_load = 1'b1;
                wr_en_d = 1'b1;
                pixel_d = cmd_q.colour;
            end
            DRAW: if (!ag_done) begin
                ag_step = 1'b1;
                wr_en_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            cmd_q   <= '0;
            wr_en_q <= 1'b0;
            pixel_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            wr_en_q <= wr_en_d;
            pixel_q <= pixel_d;
            busy_q  <= busy_d;
        end
    end

    raster_addr_gen u_addr_gen (
        .clk    (clk),
        .rst_n  (n_rst_async),
        .load_i (ag_load),
        .step_i (ag_step),
        .x0_i   (rx0),
        .y0_i   (ry0),
        .x1_i   (rx1),
        .y1_i   (ry1),
        .addr_o (fb_write_addr),
        .done_c (ag_done)
    );

    assign fb_write_en    = wr_en_q;
    assign fb_write_pixel = pixel_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_rasterizer.sv
// Self-checking bench for rasterizer: vector table, random commands against a
// region-level write model, back-to-back and mid-draw reset sequences.
module tb_rasterizer;
    import vgacpu_pkg::*;

    localparam int W = 214;
    localparam int H = 160;

    logic     clk = 1'b0;
    logic     n_rst_async = 1'b1;
    logic     busy;
    logic     fb_write_en;
    fb_addr_t fb_write_addr;
    pixel_t   fb_write_pixel;

    int errors = 0;
    int checks = 0;

    rasterizer_if cif ();

    rasterizer dut (
        .clk            (clk),
        .n_rst_async    (n_rst_async),
        .cmd            (cif.slave),
        .busy           (busy),
        .fb_write_en    (fb_write_en),
        .fb_write_addr  (fb_write_addr),
        .fb_write_pixel (fb_write_pixel)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input int op, input int x0, input int y0,
                         input int x1, input int y1, input int col);
        cif.cmd_op     = raster_op_e'(2'(op));
        cif.cmd_x0     = 8'(x0);
        cif.cmd_y0     = 8'(y0);
        cif.cmd_x1     = 8'(x1);
        cif.cmd_y1     = 8'(y1);
        cif.cmd_colour = 3'(col);
    endtask

    task automatic scramble();
        drive(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
    endtask

    // Issue one command, capture the write stream and compare with the model
    task automatic run_cmd(input string name, input int op, input int x0, input int y0,
                           input int x1, input int y1, input int col,
                           output int n_out, output int first_out);
        int exp_a[$];
        int got_a[$];
        int ax0, ay0, ax1, ay1;
        int k, first_k, pix_bad, busy_bad, range_bad, diff, lim;
        ax0 = x0; ay0 = y0; ax1 = x1; ay1 = y1;
        if (op == 1) begin
            ax1 = x0; ay1 = y0;
        end else if (op == 3) begin
            ax0 = 0; ay0 = 0; ax1 = W - 1; ay1 = H - 1;
        end
        if (ax1 > W - 1) ax1 = W - 1;
        if (ay1 > H - 1) ay1 = H - 1;
        if (op != 0)
            for (int y = ay0; y <= ay1; y++)
                for (int x = ax0; x <= ax1; x++)
                    exp_a.push_back(y * W + x);

        @(negedge clk);
        k = 0;
        while (!cif.cmd_ready && k < 50000) begin
            @(negedge clk);
            k++;
        end
        drive(op, x0, y0, x1, y1, col);
        cif.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cif.cmd_valid = 1'b0;
        scramble();

        k = 0; first_k = -1; pix_bad = 0; busy_bad = 0; range_bad = 0;
        while (1) begin
            @(negedge clk);
            k++;
            if (fb_write_en) begin
                got_a.push_back(int'(fb_write_addr));
                if (first_k < 0) first_k = k;
                if (int'(fb_write_pixel) != col) pix_bad++;
                if (int'(fb_write_addr) >= W * H) range_bad++;
            end
            if (cif.cmd_ready) break;
            if (!busy) busy_bad++;
            if (k > 40000) break;
        end

        check({name, ".count"}, got_a.size(), exp_a.size());
        diff = 0;
        lim = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
        for (int i = 0; i < lim; i++)
            if (got_a[i] != exp_a[i]) diff++;
        check({name, ".stream"}, diff, 0);
        check({name, ".pixel"}, pix_bad, 0);
        check({name, ".range"}, range_bad, 0);
        check({name, ".busy"}, busy_bad, 0);
        check({name, ".ready_cyc"}, k, (op == 0) ? 1 : exp_a.size() + 2);
        if (exp_a.size() > 0) check({name, ".first_cyc"}, first_k, 2);
        n_out     = got_a.size();
        first_out = (got_a.size() > 0) ? got_a[0] : -1;
    endtask

    typedef struct {
        string name;
        int    op, x0, y0, x1, y1, col;
        int    exp_n, exp_first;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n, f, bb_k, idx, diff;
        int bb_a[$];
        int bb_p[$];

        vecs[0]  = '{"plot_10_2",    1,  10,   2,   0,   0, 5,     1,   438};
        vecs[1]  = '{"fill_clip",    2, 212,   0, 250,   1, 3,     4,   212};
        vecs[2]  = '{"fill_empty_x", 2,  20,   0,  10,   5, 6,     0,    -1};
        vecs[3]  = '{"nop",          0,   5,   5,   9,   9, 7,     0,    -1};
        vecs[4]  = '{"plot_corner",  1, 213, 159,   0,   0, 2,     1, 34239};
        vecs[5]  = '{"plot_x_oob",   1, 214,   0,   0,   0, 4,     0,    -1};
        vecs[6]  = '{"plot_y_oob",   1,   0, 160,   0,   0, 4,     0,    -1};
        vecs[7]  = '{"fill_row",     2,   5,  10,   7,  10, 6,     3,  2145};
        vecs[8]  = '{"fill_clip_br", 2, 200, 150, 255, 255, 7,   140, 32300};
        vecs[9]  = '{"fill_empty_y", 2,   3,   5,   3,   4, 1,     0,    -1};
        vecs[10] = '{"fill_sq",      2,   0,   0,   1,   1, 4,     4,     0};
        vecs[11] = '{"clear",        3,   9,   9,   0,   0, 1, 34240,     0};

        cif.cmd_valid = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #2 n_rst_async = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.en_during", int'(fb_write_en), 0);
        n_rst_async = 1'b1;
        @(negedge clk);
        check("rst.ready", int'(cif.cmd_ready), 1);
        check("rst.busy", int'(busy), 0);
        check("rst.en", int'(fb_write_en), 0);
        check("rst.addr", int'(fb_write_addr), 0);
        check("rst.pixel", int'(fb_write_pixel), 0);

        for (int i = 0; i < 12; i++) begin
            run_cmd(vecs[i].name, vecs[i].op, vecs[i].x0, vecs[i].y0,
                    vecs[i].x1, vecs[i].y1, vecs[i].col, n, f);
            check({vecs[i].name, ".n"}, n, vecs[i].exp_n);
            check({vecs[i].name, ".first_addr"}, f, vecs[i].exp_first);
        end

        // cmd_valid held high across alternating PLOTs
        @(negedge clk);
        idx = 0; bb_k = 0;
        drive(1, 0, 0, 0, 0, 1);
        cif.cmd_valid = 1'b1;
        while (1) begin
            if (bb_k > 0) @(negedge clk);
            bb_k++;
            if (fb_write_en) begin
                bb_a.push_back(int'(fb_write_addr));
                bb_p.push_back(int'(fb_write_pixel));
            end
            if (cif.cmd_ready) begin
                if (idx == 6) break;
                @(posedge clk);
                #1;
                idx++;
                if (idx < 6) drive(1, idx * 3, idx, 0, 0, idx + 1);
                else cif.cmd_valid = 1'b0;
            end
            if (bb_k > 500) break;
        end
        check("b2b.count", bb_a.size(), 6);
        diff = 0;
        for (int i = 0; i < 6 && i < bb_a.size(); i++)
            if (bb_a[i] != i * W + i * 3 || bb_p[i] != i + 1) diff++;
        check("b2b.stream", diff, 0);
        check("b2b.cycles", bb_k, 19);

        for (int r = 0; r < 40; r++) begin
            int op, x0, y0, x1, y1, col;
            op  = int'($urandom_range(0, 2));
            x0  = int'($urandom_range(0, 230));
            y0  = int'($urandom_range(0, 170));
            x1  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                              : (x0 + int'($urandom_range(0, 6))) & 255;
            y1  = y0 + int'($urandom_range(0, 3));
            if (y0 > 0 && $urandom_range(0, 7) == 0) y1 = y0 - 1;
            col = int'($urandom_range(0, 7));
            run_cmd($sformatf("rnd%0d", r), op, x0, y0, x1, y1, col, n, f);
        end

        // Reset asserted between edges in the middle of a CLEAR
        @(negedge clk);
        drive(3, 0, 0, 0, 0, 2);
        cif.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cif.cmd_valid = 1'b0;
        repeat (100) @(negedge clk);
        check("rst_mid.pre_en", int'(fb_write_en), 1);
        check("rst_mid.pre_busy", int'(busy), 1);
        #2 n_rst_async = 1'b0;
        #1;
        check("rst_mid.en", int'(fb_write_en), 0);
        check("rst_mid.busy", int'(busy), 0);
        check("rst_mid.ready", int'(cif.cmd_ready), 1);
        @(negedge clk);
        n_rst_async = 1'b1;
        @(negedge clk);
        check("rst_mid.post_ready", int'(cif.cmd_ready), 1);
        check("rst_mid.post_en", int'(fb_write_en), 0);
        run_cmd("post_rst_plot", 1, 0, 0, 0, 0, 3, n, f);
        check("post_rst_plot.n", n, 1);
        check("post_rst_plot.first_addr", f, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
